// File: rtl/life_pkg.sv
// Shared types and defaults for the Game-of-Life board, row decoders and sequencer.
package life_pkg;

  localparam int unsigned LIFE_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/life_tick_divider.sv
// Free-running pace counter for run mode; tick is high in the last count of each period.
module life_tick_divider #(
  parameter int unsigned TICK_DIV = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/life_generation_sequencer.sv
// Scans board rows through the row decoder, pulses commit, then reports one finished generation.
module life_generation_sequencer
  import life_pkg::*;
#(
  parameter int unsigned ROWS     = LIFE_ROWS,
  parameter int unsigned TICK_DIV = 3,
  parameter int unsigned GEN_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      step,
  output logic                      row_ena,
  output logic [$clog2(ROWS)-1:0]   row_sel,
  output logic                      commit,
  output logic                      busy,
  output logic                      gen_done,
  output logic [GEN_W-1:0]          generation
);

  localparam int unsigned ROW_BITS = $clog2(ROWS);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  seq_state_t          state;
  logic [ROW_BITS-1:0] row_cnt;
  logic [GEN_W-1:0]    gen_cnt;
  logic                tick;
  logic                idle;
  logic                start;

  assign idle  = (state == IDLE);
  // Step and a coinciding run tick merge into a single start.
  assign start = idle && (step || (run && tick));

  life_tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run || !idle || start),
    .enable(idle),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      gen_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          row_cnt <= '0;
          if (start) state <= SCAN;
        end
        SCAN: begin
          if (row_cnt == LAST_ROW) begin
            row_cnt <= '0;
            state   <= COMMIT;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        COMMIT: begin
          gen_cnt <= gen_cnt + 1'b1;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign row_ena    = (state == SCAN);
  assign row_sel    = (state == SCAN) ? row_cnt : '0;
  assign commit     = (state == COMMIT);
  assign busy       = !idle;
  assign gen_done   = (state == DONE);
  assign generation = gen_cnt;

endmodule

// File: tb/tb_life_generation_sequencer.sv
// Directed checks of the generation sequencer with ROWS=4, TICK_DIV=3, GEN_W=8.
module tb_life_generation_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       row_ena;
  logic [1:0] row_sel;
  logic       commit;
  logic       busy;
  logic       gen_done;
  logic [7:0] generation;

  int n_cmp  = 0;
  int n_fail = 0;
  int commit_cnt = 0;

  typedef struct {
    logic       run;
    logic       step;
    logic       ena;
    logic [1:0] sel;
    logic       com;
    logic       bsy;
    logic       done;
    logic [7:0] gen;
  } vec_t;

  vec_t vecs[15];

  life_generation_sequencer #(
    .ROWS    (4),
    .TICK_DIV(3),
    .GEN_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .row_ena   (row_ena),
    .row_sel   (row_sel),
    .commit    (commit),
    .busy      (busy),
    .gen_done  (gen_done),
    .generation(generation)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && commit) commit_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ena, input logic [1:0] sel,
                          input logic com, input logic bsy, input logic done,
                          input logic [7:0] gen);
    chk({tag, ".row_ena"},    int'(row_ena),    int'(ena));
    chk({tag, ".row_sel"},    int'(row_sel),    int'(sel));
    chk({tag, ".commit"},     int'(commit),     int'(com));
    chk({tag, ".busy"},       int'(busy),       int'(bsy));
    chk({tag, ".gen_done"},   int'(gen_done),   int'(done));
    chk({tag, ".generation"}, int'(generation), int'(gen));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    step = 1'b0;
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    commit_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      cyc();
      k++;
    end
    if (busy) chk({name, ".idle_timeout"}, 1, 0);
  endtask

  // One step request; returns whether gen_done was seen within the budget.
  task automatic do_step(output bit saw_done);
    saw_done = 1'b0;
    step = 1'b1;
    cyc();
    step = 1'b0;
    for (int k = 0; k < 12 && !saw_done; k++) begin
      if (gen_done) saw_done = 1'b1;
      else cyc();
    end
    cyc();
  endtask

  initial begin
    bit saw;
    int first_scan;
    int done_at[$];

    // Step generation, then a step pulsed mid-scan that must be ignored.
    //          run   step  ena   sel   com   bsy   done  gen
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2};

    // Reset state, checked while reset is still asserted.
    run = 1'b0;
    step = 1'b0;
    rst_n = 1'b0;
    #12;
    chk_outs("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_outs("idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    for (int i = 0; i < 15; i++) begin
      run  = vecs[i].run;
      step = vecs[i].step;
      cyc();
      chk_outs($sformatf("vec%0d", i), vecs[i].ena, vecs[i].sel, vecs[i].com,
               vecs[i].bsy, vecs[i].done, vecs[i].gen);
    end
    step = 1'b0;
    chk("step_mid_scan.commits", commit_cnt, 2);

    // Run mode: first scan on the third edge, gen_done every 9 cycles.
    do_reset();
    first_scan = -1;
    for (int e = 1; e <= 30; e++) begin
      run = 1'b1;
      cyc();
      if (row_ena && first_scan < 0) first_scan = e;
      if (gen_done) done_at.push_back(e);
    end
    run = 1'b0;
    chk("run.first_scan", first_scan, 3);
    chk("run.done_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      chk("run.done0", done_at[0], 8);
      chk("run.period1", done_at[1] - done_at[0], 9);
      chk("run.period2", done_at[2] - done_at[1], 9);
    end
    chk("run.gen_at_30", int'(generation), 3);
    // A generation started on edge 30 must finish although run dropped.
    chk("run.busy_after_drop", int'(busy), 1);
    wait_idle("run_drop", 10);
    chk("run_drop.generation", int'(generation), 4);
    chk("run_drop.commits", commit_cnt, 4);
    repeat (12) cyc();
    chk("run_drop.stays_idle", int'(busy), 0);

    // Step coinciding with the run tick gives one generation.
    do_reset();
    run = 1'b1;
    repeat (2) cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    run = 1'b0;
    chk("coincide.scan", int'(row_ena), 1);
    wait_idle("coincide", 10);
    repeat (3) cyc();
    chk("coincide.generation", int'(generation), 1);
    chk("coincide.commits", commit_cnt, 1);

    // Reset during the third scan cycle aborts without a commit.
    do_reset();
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (2) cyc();
    chk("abort.row_sel", int'(row_sel), 2);
    rst_n = 1'b0;
    #1;
    chk("abort.row_ena_async", int'(row_ena), 0);
    chk("abort.busy_async", int'(busy), 0);
    cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    chk("abort.commits", commit_cnt, 0);
    chk("abort.generation", int'(generation), 0);

    // Generation counter wraps after 256 steps.
    do_reset();
    for (int i = 0; i < 255; i++) do_step(saw);
    chk("wrap.preload", int'(generation), 255);
    do_step(saw);
    chk("wrap.gen_done", int'(saw), 1);
    chk("wrap.generation", int'(generation), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
